// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared FSM encoding and sizing constants for the UART scheduler
package uart_tx_sched_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOCK = 2'd1, SEND = 2'd2} state_t;
   localparam int N_REQ = 4;
   localparam int TIMEOUT_DEF = 1_250_000;
   localparam int CNT_W = 21;
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester byte streams plus the uart_tx din/din_vld/rdy handshake
//   req_data/req_vld/req_last : per-requester byte, valid and end-of-packet
//   req_rdy                   : one-cycle acknowledge per requester
//   tx_rdy/tx_din/tx_din_vld  : handshake with the uart_tx serializer
interface uart_tx_sched_if;
   import uart_tx_sched_pkg::*;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_vld;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_rdy;
   logic               tx_rdy;
   logic [7:0]         tx_din;
   logic               tx_din_vld;
   modport master (output req_data, req_vld, req_last, tx_rdy, input req_rdy, tx_din, tx_din_vld);
   modport slave (input req_data, req_vld, req_last, tx_rdy, output req_rdy, tx_din, tx_din_vld);
endinterface

// File: rtl/uart_tx_sched_arb.sv
// rr_arbiter4: combinational 4-way round-robin pick starting at ptr
//   req     : request vector
//   ptr     : highest-priority index
//   gnt_idx : first set request at or after ptr, modulo 4
//   any     : at least one request is set
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       any
);
   logic [7:0] dbl;
   logic [3:0] rot;
   logic [1:0] off;
   // rot[k] is req[(ptr+k)%4], so the offset is a fixed-priority search
   assign dbl = {req, req};
   assign rot = dbl[ptr +: 4];
   assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   assign gnt_idx = ptr + off;
   assign any = |req;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-granular round-robin scheduler feeding one uart_tx from four requesters
//   clk_125m, rst_n : clock and asynchronous active-low reset
//   bus             : requester streams and uart_tx handshake (slave side)
//   gnt_id          : current or last granted requester
//   busy            : FSM is not idle
//   timeout_err     : one-cycle pulse when a stalled grant is forcibly released
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_125m,
   input  logic              rst_n,
   uart_tx_sched_if.slave    bus,
   output logic [1:0]        gnt_id,
   output logic              busy,
   output logic              timeout_err
);
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       rr_ptr, ptr_n, gnt_n, pick;
   logic             any, last_q, last_n, vld_n, terr_n;
   logic [7:0]       din_n;
   logic [N_REQ-1:0] rdy_n;

   rr_arbiter4 u_arb (.req(bus.req_vld), .ptr(rr_ptr), .gnt_idx(pick), .any(any));

   assign busy = state != IDLE;

   // tx_din_vld is high exactly in the first SEND cycle, when uart_tx's rdy is not yet meaningful
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      ptr_n = rr_ptr;
      gnt_n = gnt_id;
      last_n = last_q;
      din_n = bus.tx_din;
      vld_n = 1'b0;
      rdy_n = '0;
      terr_n = 1'b0;
      case (state)
         IDLE:
            if (any && bus.tx_rdy) begin
               gnt_n = pick;
               cnt_n = '0;
               state_n = LOCK;
            end
         LOCK: begin
            cnt_n = cnt + CNT_W'(1);
            if (bus.req_vld[gnt_id]) begin
               din_n = bus.req_data[{gnt_id, 3'b000} +: 8];
               vld_n = 1'b1;
               rdy_n = N_REQ'(1) << gnt_id;
               last_n = bus.req_last[gnt_id];
               state_n = SEND;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               terr_n = 1'b1;
               ptr_n = gnt_id + 2'd1;
               state_n = IDLE;
            end
         end
         SEND:
            if (!bus.tx_din_vld && bus.tx_rdy) begin
               ptr_n = last_q ? gnt_id + 2'd1 : rr_ptr;
               cnt_n = '0;
               state_n = last_q ? IDLE : LOCK;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_125m or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         rr_ptr <= '0;
         gnt_id <= '0;
         last_q <= 1'b0;
         timeout_err <= 1'b0;
         bus.tx_din <= '0;
         bus.tx_din_vld <= 1'b0;
         bus.req_rdy <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         rr_ptr <= ptr_n;
         gnt_id <= gnt_n;
         last_q <= last_n;
         timeout_err <= terr_n;
         bus.tx_din <= din_n;
         bus.tx_din_vld <= vld_n;
         bus.req_rdy <= rdy_n;
      end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench for the UART requester scheduler
module tb_uart_tx_sched;
   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] gnt_id;
   logic busy, timeout_err;
   int checks = 0, failures = 0, cyc = 0, m_ptr = 0, fcnt = 0;
   logic [9:0] sb[$];
   logic [8:0] bq[4][$];
   int gap[4];
   logic [9:0] e;

   uart_tx_sched_if ifc ();
   uart_tx_sched #(.TIMEOUT(100)) dut (.clk_125m(clk), .rst_n(rst_n), .bus(ifc), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err));

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in: rdy low while din_vld is up and for a random frame length after
   always @(posedge clk or negedge rst_n)
      if (!rst_n) fcnt <= 0;
      else if (ifc.tx_din_vld) fcnt <= $urandom_range(2, 12);
      else if (fcnt != 0) fcnt <= fcnt - 1;
   assign ifc.tx_rdy = fcnt == 0 && !ifc.tx_din_vld;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rst_n) begin
         if (ifc.tx_din_vld) begin
            if (sb.size() == 0) chk("unexpected_byte", {22'd0, gnt_id, ifc.tx_din}, 32'hffffffff);
            else begin
               e = sb.pop_front();
               chk("tx_din", ifc.tx_din, e[7:0]);
               chk("gnt_id", gnt_id, e[9:8]);
               chk("req_rdy", ifc.req_rdy, 4'b0001 << e[9:8]);
            end
         end else chk("req_rdy_quiet", ifc.req_rdy, 0);
      end

   task automatic add_byte(input int i, input logic [7:0] b, input logic l);
      bq[i].push_back({l, b});
   endtask

   task automatic add_pkt(input int i, input int len);
      for (int k = 0; k < len; k++) add_byte(i, 8'($urandom), k == len - 1);
   endtask

   task automatic present();
      logic [31:0] d;
      logic [3:0] v, l;
      d = '0; v = '0; l = '0;
      for (int i = 0; i < 4; i++)
         if (bq[i].size() != 0 && gap[i] == 0) begin
            v[i] = 1'b1;
            d[8*i +: 8] = bq[i][0][7:0];
            l[i] = bq[i][0][8];
         end
      ifc.req_data = d;
      ifc.req_vld = v;
      ifc.req_last = l;
   endtask

   // Reference: whole packets are granted round-robin over requesters that still have data
   task automatic run_phase();
      logic [8:0] mq[4][$];
      logic [8:0] w;
      int sel, n;
      bit found, done;
      for (int i = 0; i < 4; i++) begin mq[i] = bq[i]; gap[i] = 0; end
      forever begin
         found = 0;
         sel = 0;
         for (int k = 0; k < 4; k++)
            if (!found && mq[(m_ptr + k) % 4].size() != 0) begin found = 1; sel = (m_ptr + k) % 4; end
         if (!found) break;
         do begin
            w = mq[sel].pop_front();
            sb.push_back({2'(sel), w[7:0]});
         end while (!w[8]);
         m_ptr = (sel + 1) % 4;
      end
      n = 0;
      done = 0;
      while (!done && n < 20000) begin
         present();
         @(negedge clk);
         n++;
         chk("no_spurious_timeout", timeout_err, 0);
         for (int i = 0; i < 4; i++)
            if (ifc.req_rdy[i]) begin
               w = bq[i].pop_front();
               gap[i] = w[8] ? 0 : $urandom_range(0, 3);
            end else if (gap[i] > 0) gap[i]--;
         done = !busy && sb.size() == 0;
         for (int i = 0; i < 4; i++) if (bq[i].size() != 0) done = 0;
      end
      present();
      chk("phase_done", done, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin @(negedge clk); n++; end
      chk("idle", busy, 0);
   endtask

   task automatic to_case(input bit boundary);
      logic [7:0] b, b2;
      int n, t0, tfire;
      b = 8'($urandom);
      b2 = 8'($urandom);
      tfire = -1;
      @(negedge clk);
      ifc.req_data = {b, 24'd0};
      ifc.req_last = 4'b0000;
      ifc.req_vld = 4'b1000;
      sb.push_back({2'd3, b});
      n = 0;
      do begin @(negedge clk); n++; end while (!ifc.req_rdy[3] && n < 50);
      chk("to_ack", ifc.req_rdy[3], 1);
      ifc.req_vld = 4'b0000;
      n = 0;
      do begin @(negedge clk); n++; end while (!ifc.tx_rdy && n < 50);
      t0 = cyc;
      for (int j = 0; j < 150; j++) begin
         @(negedge clk);
         if (ifc.req_rdy[3]) ifc.req_vld = 4'b0000;
         if (timeout_err && tfire < 0) begin
            tfire = cyc;
            chk("idle_at_timeout", busy, 0);
         end
         if (boundary && cyc == t0 + 100) begin
            ifc.req_data = {b2, 24'd0};
            ifc.req_last = 4'b1000;
            ifc.req_vld = 4'b1000;
            sb.push_back({2'd3, b2});
         end
      end
      if (boundary) chk("boundary_no_timeout", tfire, -1);
      else chk("timeout_cycle", tfire, t0 + 101);
      wait_idle();
      chk("to_sb_drained", sb.size(), 0);
      m_ptr = 0;
   endtask

   task automatic reset_case();
      logic [7:0] b;
      int n, t;
      b = 8'($urandom);
      @(negedge clk);
      ifc.req_data = {24'd0, b};
      ifc.req_last = 4'b0000;
      ifc.req_vld = 4'b0001;
      sb.push_back({2'd0, b});
      n = 0;
      do begin @(negedge clk); n++; end while (!ifc.req_rdy[0] && n < 50);
      ifc.req_vld = 4'b0000;
      @(negedge clk);
      chk("busy_mid_send", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_tx_din", ifc.tx_din, 0);
      chk("rst_tx_din_vld", ifc.tx_din_vld, 0);
      chk("rst_req_rdy", ifc.req_rdy, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      sb.delete();
      m_ptr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      b = 8'($urandom);
      t = cyc;
      ifc.req_data = {24'd0, b};
      ifc.req_last = 4'b0001;
      ifc.req_vld = 4'b0001;
      sb.push_back({2'd0, b});
      n = 0;
      do begin @(negedge clk); n++; end while (!ifc.tx_din_vld && n < 20);
      chk("first_byte_latency", cyc - t, 2);
      ifc.req_vld = 4'b0000;
      wait_idle();
      m_ptr = 1;
   endtask

   initial begin
      rst_n = 1'b0;
      ifc.req_data = '0;
      ifc.req_vld = '0;
      ifc.req_last = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx_din", ifc.tx_din, 0);
      chk("rst_tx_din_vld", ifc.tx_din_vld, 0);
      chk("rst_req_rdy", ifc.req_rdy, 0);
      chk("rst_gnt_id", gnt_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin add_pkt(i, 1); add_pkt(i, 1); end
      run_phase();
      add_byte(2, 8'h55, 1'b0);
      add_byte(2, 8'hA3, 1'b1);
      run_phase();
      add_pkt(0, 2);
      run_phase();
      add_pkt(1, 3);
      add_pkt(0, 1);
      run_phase();
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 4; i++)
            for (int k = $urandom_range(0, 3); k > 0; k--) add_pkt(i, $urandom_range(1, 4));
         run_phase();
      end
      to_case(1'b0);
      to_case(1'b1);
      for (int i = 0; i < 4; i++) add_pkt(i, $urandom_range(1, 3));
      run_phase();
      reset_case();
      for (int i = 0; i < 4; i++) add_pkt(i, $urandom_range(1, 3));
      run_phase();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
